// File: rtl/kcpu_pkg.sv
// rtl/kcpu_pkg.sv - shared types, widths and flag-merge helper for the writeback stage
// Contents:
//   KCPU_*_W        default datapath widths
//   FLAG_Z..FLAG_V  bit positions inside the {V,N,C,Z} status vector
//   flags_t         status / mask vector type
//   wb_entry_t      one buffered ALU result awaiting retire
//   merge_flags     masked status update (mask bit 1 = take new value)
package kcpu_pkg;

    localparam int KCPU_DATA_W = 32;
    localparam int KCPU_REG_W  = 4;
    localparam int KCPU_FLAG_W = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef logic [3:0] flags_t;

    typedef struct packed {
        logic [KCPU_DATA_W-1:0] data;
        flags_t                 flags;
        flags_t                 mask;
        logic [KCPU_REG_W-1:0]  dest;
        logic                   we;
    } wb_entry_t;

    function automatic flags_t merge_flags(input flags_t old_flags,
                                           input flags_t new_flags,
                                           input flags_t mask);
        return (old_flags & ~mask) | (new_flags & mask);
    endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// rtl/alu_writeback_stage_if.sv - ALU-result input and register-file output handshakes
// Signals:
//   in_valid/in_ready + in_data/in_flags/in_flags_mask/in_dest/in_we   ALU side
//   out_valid/out_ready + out_data/out_dest/out_we                     register-file side
// Modports:
//   slave   the writeback stage
//   master  the surrounding pipeline (ALU driver and register-file sink)
interface alu_writeback_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int FLAG_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [FLAG_W-1:0] in_flags;
    logic [FLAG_W-1:0] in_flags_mask;
    logic [REG_W-1:0]  in_dest;
    logic              in_we;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [REG_W-1:0]  out_dest;
    logic              out_we;

    modport slave (
        input  in_valid, in_data, in_flags, in_flags_mask, in_dest, in_we, out_ready,
        output in_ready, out_valid, out_data, out_dest, out_we
    );

    modport master (
        output in_valid, in_data, in_flags, in_flags_mask, in_dest, in_we, out_ready,
        input  in_ready, out_valid, out_data, out_dest, out_we
    );
endinterface

// File: rtl/wb_entry_fifo.sv
// rtl/wb_entry_fifo.sv - 2-entry in-order elastic buffer of writeback entries
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   flush                   drop every held entry at the next edge (a same-cycle pop still happens)
//   in_valid, in_ready      push handshake; in_ready depends only on count and flush
//   in_entry                entry to push
//   out_valid, out_ready    pop handshake on the head entry
//   head                    entry e0 (meaningful only while out_valid)
//   pop                     head is retiring this cycle
import kcpu_pkg::*;

module wb_entry_fifo (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    input  logic      in_valid,
    output logic      in_ready,
    input  wb_entry_t in_entry,
    output logic      out_valid,
    input  logic      out_ready,
    output wb_entry_t head,
    output logic      pop
);
    logic [1:0] count, count_n;
    wb_entry_t  e0, e0_n, e1, e1_n;
    logic       push;

    // in_ready never looks at out_ready: a full buffer stays closed even while it pops.
    assign in_ready  = (count != 2'd2) && !flush;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = e0;

    always_comb begin
        count_n = count;
        e0_n    = e0;
        e1_n    = e1;
        if (flush) begin
            count_n = 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        e0_n    = in_entry;
                        count_n = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        e0_n = in_entry;
                    end else if (push) begin
                        e1_n    = in_entry;
                        count_n = 2'd2;
                    end else if (pop) begin
                        count_n = 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        e0_n    = e1;
                        count_n = 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
            e0    <= '0;
            e1    <= '0;
        end else begin
            count <= count_n;
            e0    <= e0_n;
            e1    <= e1_n;
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// rtl/alu_writeback_stage.sv - buffers ALU results, retires them in order, owns the {V,N,C,Z} status register
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   flush        discard all un-retired entries (a pop in the same cycle still commits)
//   wb           alu_writeback_stage_if.slave: ALU input and register-file output handshakes
//   flags        architectural status register
//   flags_fwd    status as seen by the next conditional op
// Build option KCPU_FLAG_FORWARD_EN: when defined, flags_fwd shows the merged value during the
// retire cycle; otherwise flags_fwd equals flags and the update appears one cycle after retire.
import kcpu_pkg::*;

module alu_writeback_stage #(
    parameter int DATA_W = KCPU_DATA_W,
    parameter int REG_W  = KCPU_REG_W,
    parameter int FLAG_W = KCPU_FLAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    alu_writeback_stage_if.slave wb,
    output logic [FLAG_W-1:0] flags,
    output logic [FLAG_W-1:0] flags_fwd
);
    wb_entry_t         in_entry;
    wb_entry_t         head;
    logic              out_valid;
    logic              pop;
    logic [DATA_W-1:0] head_data;
    logic [REG_W-1:0]  head_dest;
    logic [FLAG_W-1:0] head_flags;
    logic [FLAG_W-1:0] head_mask;
    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] merged;

    assign in_entry = '{data:  wb.in_data,
                        flags: wb.in_flags,
                        mask:  wb.in_flags_mask,
                        dest:  wb.in_dest,
                        we:    wb.in_we};

    wb_entry_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (wb.in_valid),
        .in_ready  (wb.in_ready),
        .in_entry  (in_entry),
        .out_valid (out_valid),
        .out_ready (wb.out_ready),
        .head      (head),
        .pop       (pop)
    );

    assign head_data  = head.data;
    assign head_dest  = head.dest;
    assign head_flags = head.flags;
    assign head_mask  = head.mask;

    // Output fields read zero whenever nothing is held, so stale entries are never visible.
    assign wb.out_valid = out_valid;
    assign wb.out_data  = out_valid ? head_data : '0;
    assign wb.out_dest  = out_valid ? head_dest : '0;
    assign wb.out_we    = out_valid && head.we;

    // Flags change only when an entry retires; dropped entries never reach this merge.
    assign merged = merge_flags(flags_q, head_flags, head_mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else if (pop) begin
            flags_q <= merged;
        end
    end

    assign flags = flags_q;

`ifdef KCPU_FLAG_FORWARD_EN
    assign flags_fwd = pop ? merged : flags_q;
`else
    assign flags_fwd = flags_q;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb/tb_alu_writeback_stage.sv - directed vector bench for alu_writeback_stage
module tb_alu_writeback_stage;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [3:0]  fl;
        logic [3:0]  msk;
        logic [3:0]  dst;
        logic        we;
        logic        ordy;
        logic        fsh;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_od;
        logic [3:0]  e_dst;
        logic        e_we;
        logic [3:0]  e_flags;
        logic [3:0]  e_fwd_on;
        logic [3:0]  e_fwd_off;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic [3:0] flags;
    logic [3:0] flags_fwd;

    int vectors = 0;
    int miscompares = 0;

    alu_writeback_stage_if wb_if ();

    alu_writeback_stage dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .wb        (wb_if),
        .flags     (flags),
        .flags_fwd (flags_fwd)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic [3:0] fl,
                                input logic [3:0] msk, input logic [3:0] dst, input logic we,
                                input logic ordy, input logic fsh,
                                input logic e_ov, input logic e_ir, input logic [31:0] e_od,
                                input logic [3:0] e_dst, input logic e_we, input logic [3:0] e_flags,
                                input logic [3:0] e_fwd_on, input logic [3:0] e_fwd_off);
        vec_t v;
        v.iv = iv; v.d = d; v.fl = fl; v.msk = msk; v.dst = dst; v.we = we;
        v.ordy = ordy; v.fsh = fsh;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_od = e_od; v.e_dst = e_dst; v.e_we = e_we;
        v.e_flags = e_flags; v.e_fwd_on = e_fwd_on; v.e_fwd_off = e_fwd_off;
        return v;
    endfunction

    task automatic chk(input string name, input int vi, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s vec %0d: got 0x%0h, expected 0x%0h", name, vi, act, exp);
            miscompares++;
        end
    endtask

    task automatic apply_vec(input vec_t v, input int vi);
        logic [3:0] exp_fwd;
        @(negedge clk);
        wb_if.in_valid      = v.iv;
        wb_if.in_data       = v.d;
        wb_if.in_flags      = v.fl;
        wb_if.in_flags_mask = v.msk;
        wb_if.in_dest       = v.dst;
        wb_if.in_we         = v.we;
        wb_if.out_ready     = v.ordy;
        flush               = v.fsh;
        #1;
`ifdef KCPU_FLAG_FORWARD_EN
        exp_fwd = v.e_fwd_on;
`else
        exp_fwd = v.e_fwd_off;
`endif
        vectors++;
        chk("out_valid", vi, 32'(wb_if.out_valid), 32'(v.e_ov));
        chk("in_ready",  vi, 32'(wb_if.in_ready),  32'(v.e_ir));
        chk("out_data",  vi, wb_if.out_data,       v.e_od);
        chk("out_dest",  vi, 32'(wb_if.out_dest),  32'(v.e_dst));
        chk("out_we",    vi, 32'(wb_if.out_we),    32'(v.e_we));
        chk("flags",     vi, 32'(flags),           32'(v.e_flags));
        chk("flags_fwd", vi, 32'(flags_fwd),       32'(exp_fwd));
    endtask

    vec_t tbl[$];

    initial begin
        wb_if.in_valid      = 1'b0;
        wb_if.in_data       = '0;
        wb_if.in_flags      = '0;
        wb_if.in_flags_mask = '0;
        wb_if.in_dest       = '0;
        wb_if.in_we         = 1'b0;
        wb_if.out_ready     = 1'b0;

        //          iv  data   fl       msk      dst we ordy fsh | ov ir out     dst we flags    fwd_on   fwd_off
        tbl.push_back(mk(0, 32'h00, 4'b0000, 4'b0000, 0,  0, 0, 0,   0, 1, 32'h00, 0,  0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 32'h00, 4'b0101, 4'b1111, 1,  1, 1, 0,   0, 1, 32'h00, 0,  0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 32'h00, 4'b0000, 4'b0000, 0,  0, 1, 0,   1, 1, 32'h00, 1,  1, 4'b0000, 4'b0101, 4'b0000));
        tbl.push_back(mk(0, 32'h00, 4'b0000, 4'b0000, 0,  0, 0, 0,   0, 1, 32'h00, 0,  0, 4'b0101, 4'b0101, 4'b0101));
        tbl.push_back(mk(1, 32'h11, 4'b1010, 4'b1111, 2,  0, 0, 0,   0, 1, 32'h00, 0,  0, 4'b0101, 4'b0101, 4'b0101));
        tbl.push_back(mk(0, 32'h00, 4'b0000, 4'b0000, 0,  0, 1, 0,   1, 1, 32'h11, 2,  0, 4'b0101, 4'b1010, 4'b0101));
        tbl.push_back(mk(1, 32'h22, 4'b0100, 4'b0101, 3,  1, 1, 0,   0, 1, 32'h00, 0,  0, 4'b1010, 4'b1010, 4'b1010));
        tbl.push_back(mk(0, 32'h00, 4'b0000, 4'b0000, 0,  0, 1, 0,   1, 1, 32'h22, 3,  1, 4'b1010, 4'b1110, 4'b1010));
        tbl.push_back(mk(1, 32'h31, 4'b0001, 4'b0001, 4,  1, 0, 0,   0, 1, 32'h00, 0,  0, 4'b1110, 4'b1110, 4'b1110));
        tbl.push_back(mk(1, 32'h32, 4'b0000, 4'b0000, 5,  1, 0, 0,   1, 1, 32'h31, 4,  1, 4'b1110, 4'b1110, 4'b1110));
        tbl.push_back(mk(1, 32'h33, 4'b1000, 4'b1000, 6,  0, 0, 0,   1, 0, 32'h31, 4,  1, 4'b1110, 4'b1110, 4'b1110));
        tbl.push_back(mk(1, 32'h33, 4'b1000, 4'b1000, 6,  0, 0, 0,   1, 0, 32'h31, 4,  1, 4'b1110, 4'b1110, 4'b1110));
        tbl.push_back(mk(1, 32'h33, 4'b1000, 4'b1000, 6,  0, 1, 0,   1, 0, 32'h31, 4,  1, 4'b1110, 4'b1111, 4'b1110));
        tbl.push_back(mk(1, 32'h33, 4'b1000, 4'b1000, 6,  0, 1, 0,   1, 1, 32'h32, 5,  1, 4'b1111, 4'b1111, 4'b1111));
        tbl.push_back(mk(1, 32'h41, 4'b0000, 4'b0001, 7,  1, 1, 0,   1, 1, 32'h33, 6,  0, 4'b1111, 4'b1111, 4'b1111));
        tbl.push_back(mk(1, 32'h42, 4'b0000, 4'b0010, 8,  1, 1, 0,   1, 1, 32'h41, 7,  1, 4'b1111, 4'b1110, 4'b1111));
        tbl.push_back(mk(1, 32'h43, 4'b0000, 4'b0000, 9,  0, 1, 0,   1, 1, 32'h42, 8,  1, 4'b1110, 4'b1100, 4'b1110));
        tbl.push_back(mk(1, 32'h44, 4'b0000, 4'b0100, 10, 1, 1, 0,   1, 1, 32'h43, 9,  0, 4'b1100, 4'b1100, 4'b1100));
        tbl.push_back(mk(0, 32'h00, 4'b0000, 4'b0000, 0,  0, 1, 0,   1, 1, 32'h44, 10, 1, 4'b1100, 4'b1000, 4'b1100));
        tbl.push_back(mk(1, 32'h51, 4'b0011, 4'b0011, 11, 1, 0, 0,   0, 1, 32'h00, 0,  0, 4'b1000, 4'b1000, 4'b1000));
        tbl.push_back(mk(1, 32'h52, 4'b0100, 4'b0100, 12, 1, 0, 0,   1, 1, 32'h51, 11, 1, 4'b1000, 4'b1000, 4'b1000));
        tbl.push_back(mk(1, 32'h60, 4'b1111, 4'b1111, 14, 1, 1, 1,   1, 0, 32'h51, 11, 1, 4'b1000, 4'b1011, 4'b1000));
        tbl.push_back(mk(0, 32'h00, 4'b0000, 4'b0000, 0,  0, 1, 0,   0, 1, 32'h00, 0,  0, 4'b1011, 4'b1011, 4'b1011));

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply_vec(tbl[i], i);
        end

        // Reset in the middle of a full buffer: everything dropped at once, flags cleared.
        apply_vec(mk(1, 32'h81, 4'b1111, 4'b1111, 1, 1, 0, 0, 0, 1, 32'h00, 0, 0, 4'b1011, 4'b1011, 4'b1011), 100);
        apply_vec(mk(1, 32'h82, 4'b1111, 4'b1111, 2, 1, 0, 0, 1, 1, 32'h81, 1, 1, 4'b1011, 4'b1011, 4'b1011), 101);
        @(negedge clk);
        wb_if.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        vectors++;
        chk("rst_out_valid", 102, 32'(wb_if.out_valid), 32'd0);
        chk("rst_out_data",  102, wb_if.out_data,       32'd0);
        chk("rst_out_we",    102, 32'(wb_if.out_we),    32'd0);
        chk("rst_flags",     102, 32'(flags),           32'd0);
        chk("rst_in_ready",  102, 32'(wb_if.in_ready),  32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Forwarding: flags 0000, retire C-only update.
        apply_vec(mk(1, 32'h70, 4'b0010, 4'b0010, 13, 1, 1, 0, 0, 1, 32'h00, 0,  0, 4'b0000, 4'b0000, 4'b0000), 103);
        apply_vec(mk(0, 32'h00, 4'b0000, 4'b0000, 0,  0, 1, 0, 1, 1, 32'h70, 13, 1, 4'b0000, 4'b0010, 4'b0000), 104);
        apply_vec(mk(0, 32'h00, 4'b0000, 4'b0000, 0,  0, 0, 0, 0, 1, 32'h00, 0,  0, 4'b0010, 4'b0010, 4'b0010), 105);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
